// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// Reset value is a parameter so idle level matches the source.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lvl_to_pulse.sv
// Push-button level to single-cycle press strobe:
// synchronize, debounce, then detect the inactive-to-active edge.
module lvl_to_pulse #(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic pulse
);

    localparam logic INACT = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync2;
    logic             db;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             accept;

    sync_2ff #(
        .RST_VAL(INACT)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (lvl),
        .q  (sync2)
    );

    assign differ = (sync2 != db);
    assign accept = differ && (cnt == CNT_MAX);

    // Any return to the accepted level restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db  <= INACT;
            cnt <= '0;
        end else if (!differ) begin
            cnt <= '0;
        end else if (accept) begin
            db  <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Only the press direction strobes; release is silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse <= 1'b0;
        end else begin
            pulse <= accept && (db == INACT);
        end
    end

endmodule

// File: tb/tb_lvl_to_pulse.sv
// Directed bench for lvl_to_pulse: active-low/4-cycle and
// active-high/1-cycle instances driven from one stimulus sequence.
module tb_lvl_to_pulse;

    logic clk = 1'b0;
    logic rst;
    logic lvl_a;
    logic lvl_b;
    logic pulse_a;
    logic pulse_b;

    int tests = 0;
    int fails = 0;

    int n_pulse;
    int first_at;
    int max_w;

    always #5 clk = ~clk;

    lvl_to_pulse #(
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut_a (
        .clk  (clk),
        .rst  (rst),
        .lvl  (lvl_a),
        .pulse(pulse_a)
    );

    lvl_to_pulse #(
        .ACTIVE_LOW     (1'b0),
        .DEBOUNCE_CYCLES(1),
        .CNT_W          (4)
    ) dut_b (
        .clk  (clk),
        .rst  (rst),
        .lvl  (lvl_b),
        .pulse(pulse_b)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n edges, sampling 1 ns after each; edge 1 is the
    // first edge after the call, i.e. the capturing edge.
    task automatic run(input int n, input bit sel_b);
        int w;
        logic p;
        n_pulse  = 0;
        first_at = 0;
        max_w    = 0;
        w        = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            p = sel_b ? pulse_b : pulse_a;
            if (p === 1'b1) begin
                if (w == 0) begin
                    n_pulse++;
                    if (first_at == 0) first_at = i;
                end
                w++;
                if (w > max_w) max_w = w;
            end else begin
                w = 0;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        lvl_a = 1'b1;
        lvl_b = 1'b0;

        // 1: reset and idle
        run(3, 1'b0);
        chk("rst_pulse_a", 32'(pulse_a), 0);
        chk("rst_pulse_b", 32'(pulse_b), 0);
        chk("rst_cnt_a", n_pulse, 0);
        rst = 1'b0;
        run(100, 1'b0);
        chk("idle_cnt", n_pulse, 0);

        // 2: single press, then release
        lvl_a = 1'b0;
        run(50, 1'b0);
        chk("press_cnt", n_pulse, 1);
        chk("press_lat", first_at, 6);
        chk("press_w", max_w, 1);
        lvl_a = 1'b1;
        run(20, 1'b0);
        chk("release_cnt", n_pulse, 0);

        // 3: glitches shorter than the debounce window
        for (int g = 1; g <= 3; g++) begin
            lvl_a = 1'b0;
            run(g, 1'b0);
            chk($sformatf("glitch%0d_lo", g), n_pulse, 0);
            lvl_a = 1'b1;
            run(10, 1'b0);
            chk($sformatf("glitch%0d_hi", g), n_pulse, 0);
        end
        lvl_a = 1'b0;
        run(20, 1'b0);
        chk("steady_cnt", n_pulse, 1);
        chk("steady_lat", first_at, 6);
        lvl_a = 1'b1;
        run(20, 1'b0);
        chk("steady_rel", n_pulse, 0);

        // 4: three press/release cycles
        begin
            int tot;
            int wmax;
            tot  = 0;
            wmax = 0;
            for (int k = 0; k < 3; k++) begin
                lvl_a = 1'b0;
                run(20, 1'b0);
                tot += n_pulse;
                if (max_w > wmax) wmax = max_w;
                lvl_a = 1'b1;
                run(20, 1'b0);
                tot += n_pulse;
                if (max_w > wmax) wmax = max_w;
            end
            chk("triple_cnt", tot, 3);
            chk("triple_w", wmax, 1);
        end

        // 5: reset mid-count (cnt=2), button still held after
        lvl_a = 1'b0;
        run(4, 1'b0);
        chk("mid_nopulse", n_pulse, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_a", 32'(pulse_a), 0);
        run(2, 1'b0);
        chk("mid_rst_cnt", n_pulse, 0);
        rst = 1'b0;
        run(30, 1'b0);
        chk("post_rst_cnt", n_pulse, 1);
        chk("post_rst_lat", first_at, 6);

        // reset while the strobe is high drops it without an edge
        lvl_a = 1'b1;
        run(20, 1'b0);
        lvl_a = 1'b0;
        run(6, 1'b0);
        chk("hi_before_rst", 32'(pulse_a), 1);
        rst = 1'b1;
        #1;
        chk("async_drop", 32'(pulse_a), 0);
        lvl_a = 1'b1;
        run(3, 1'b0);
        rst = 1'b0;
        run(10, 1'b0);
        chk("after_drop", n_pulse, 0);

        // 6: active-high, single-cycle debounce
        lvl_b = 1'b1;
        run(10, 1'b1);
        chk("ah_press_cnt", n_pulse, 1);
        chk("ah_press_lat", first_at, 3);
        chk("ah_press_w", max_w, 1);
        lvl_b = 1'b0;
        run(10, 1'b1);
        chk("ah_release", n_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
